// File: rtl/opl2_host_if.sv
// Host-side write port for the OPL2 core: turns YM3812-style bus writes into
// single-cycle register-write transactions {valid, address, data} drained from a small FIFO.
module opl2_host_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_GAP    = 8
) (
  input  logic        clk,
  input  logic        ic_n,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        a0,
  input  logic [7:0]  din,
  output logic [16:0] opl2_reg_wr,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [7:0]  GAP_LOAD = 8'(MIN_GAP);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t          state;
  logic            act, act_q, strobe, push_req, push, pop;
  logic [7:0]      addr_latch;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0]     count, count_next;
  logic [15:0]     head_next;
  logic [7:0]      gap_cnt;
  logic            valid_q;
  logic [7:0]      addr_q, data_q;

  assign act        = ~cs_n & ~wr_n;
  assign strobe     = act & ~act_q;
  assign push_req   = strobe & a0;
  assign pop        = (state == EMIT);
  // A full FIFO still accepts a write in the cycle its head is being popped.
  assign push       = push_req & ((count != CNT_FULL) | pop);
  assign count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign rd_nxt     = rd_ptr + 1'b1;
  // Back-to-back emission: if only the popped entry remains, the next head is the write landing now.
  assign head_next  = (count == CNT_ONE) ? {addr_latch, din} : mem[rd_nxt];

  assign busy        = (count != '0) | (state != IDLE);
  assign opl2_reg_wr = {valid_q, addr_q, data_q};

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      act_q      <= 1'b0;
      addr_latch <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      act_q    <= act;
      overflow <= push_req & ~push;
      count    <= count_next;
      if (strobe & ~a0)
        addr_latch <= din;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {addr_latch, din};
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state            <= EMIT;
            valid_q          <= 1'b1;
            {addr_q, data_q} <= mem[rd_ptr];
          end
        end
        EMIT: begin
          if (MIN_GAP == 0) begin
            if (count_next != '0) begin
              valid_q          <= 1'b1;
              {addr_q, data_q} <= head_next;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            valid_q <= 1'b0;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1)
            state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opl2_host_if.sv
// Directed bench for opl2_host_if (FIFO_DEPTH=4, MIN_GAP=8): ordering, gap spacing,
// overflow/pop-cycle acceptance, long strobes and reset behaviour.
module tb_opl2_host_if;

  logic        clk = 1'b0;
  logic        ic_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        a0 = 1'b0;
  logic [7:0]  din = '0;
  logic [16:0] reg_wr;
  logic        busy, overflow;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int         ev_cyc[$];
  logic [7:0] ev_addr[$];
  logic [7:0] ev_data[$];
  int         ov_cyc[$];

  opl2_host_if #(.FIFO_DEPTH(4), .MIN_GAP(8)) dut (
    .clk(clk), .ic_n(ic_n), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .opl2_reg_wr(reg_wr), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ic_n) begin
      if (reg_wr[16]) begin
        ev_cyc.push_back(cyc);
        ev_addr.push_back(reg_wr[15:8]);
        ev_data.push_back(reg_wr[7:0]);
      end
      if (overflow) ov_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    ev_cyc.delete(); ev_addr.delete(); ev_data.delete(); ov_cyc.delete();
  endtask

  task automatic host_write(input logic a, input logic [7:0] d, input int len, output int scyc);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
    scyc = cyc;
    repeat (len) begin @(posedge clk); #1; end
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cs_n = i[0]; wr_n = 1'b0; a0 = i[1]; din = 8'h5A + 8'(i);
      @(negedge clk);
      n_checks++;
      if ({reg_wr, busy, overflow} !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_hold: got out=%h busy=%b ovf=%b required all 0", reg_wr, busy, overflow);
      end
    end
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = '0;
    @(posedge clk); #1;
    ic_n = 1'b1;
    clear_log();
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %b required 0", busy);
    end
    n_checks++;
    if (ev_cyc.size() != 0) begin
      n_fail++; $display("FAIL reset_release_valid: got %0d valids required 0", ev_cyc.size());
    end
  endtask

  task automatic test_single();
    int s, dmy;
    clear_log();
    host_write(1'b0, 8'hB0, 1, dmy);
    host_write(1'b1, 8'h25, 1, s);
    repeat (25) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d valids required 1", ev_cyc.size());
    end
    n_checks++;
    if ((ev_cyc.size() > 0 ? {ev_addr[0], ev_data[0]} : 16'hxxxx) !== 16'hB025) begin
      n_fail++; $display("FAIL single_value: got %h%h required b025", ev_addr[0], ev_data[0]);
    end
    n_checks++;
    if ((ev_cyc.size() > 0 ? ev_cyc[0] : -1) != s + 2) begin
      n_fail++; $display("FAIL single_latency: got cycle %0d required %0d", ev_cyc[0], s + 2);
    end
    n_checks++;
    if ({reg_wr, busy} !== {1'b0, 16'hB025, 1'b0}) begin
      n_fail++; $display("FAIL single_hold: got out=%h busy=%b required 0b025 busy 0", reg_wr, busy);
    end
  endtask

  task automatic test_gap();
    int s, dmy;
    logic [7:0] exp_d [3] = '{8'h01, 8'h02, 8'h03};
    clear_log();
    host_write(1'b0, 8'h20, 1, dmy);
    host_write(1'b1, 8'h01, 1, s);
    host_write(1'b1, 8'h02, 1, dmy);
    host_write(1'b1, 8'h03, 1, dmy);
    repeat (40) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() != 3) begin
      n_fail++; $display("FAIL gap_count: got %0d valids required 3", ev_cyc.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ((i < ev_cyc.size() ? {ev_addr[i], ev_data[i]} : 16'hxxxx) !== {8'h20, exp_d[i]}) begin
        n_fail++; $display("FAIL gap_value[%0d]: got %h%h required 20%h", i, ev_addr[i], ev_data[i], exp_d[i]);
      end
      n_checks++;
      if ((i < ev_cyc.size() ? ev_cyc[i] : -1) != s + 2 + 10 * i) begin
        n_fail++; $display("FAIL gap_timing[%0d]: got cycle %0d required %0d", i, ev_cyc[i], s + 2 + 10 * i);
      end
    end
  endtask

  task automatic test_overflow();
    int s, dmy;
    logic [7:0] exp_d [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h17};
    clear_log();
    host_write(1'b0, 8'h40, 1, dmy);
    host_write(1'b1, 8'h11, 1, s);
    for (int i = 2; i <= 7; i++) host_write(1'b1, 8'h10 + 8'(i), 1, dmy);
    repeat (70) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() != 6) begin
      n_fail++; $display("FAIL ovf_count: got %0d valids required 6", ev_cyc.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ((i < ev_cyc.size() ? {ev_addr[i], ev_data[i]} : 16'hxxxx) !== {8'h40, exp_d[i]}) begin
        n_fail++; $display("FAIL ovf_value[%0d]: got %h%h required 40%h", i, ev_addr[i], ev_data[i], exp_d[i]);
      end
    end
    n_checks++;
    if (ov_cyc.size() != 1) begin
      n_fail++; $display("FAIL ovf_pulses: got %0d pulses required 1", ov_cyc.size());
    end
    n_checks++;
    if ((ov_cyc.size() > 0 ? ov_cyc[0] : -1) != s + 11) begin
      n_fail++; $display("FAIL ovf_pulse_cycle: got %0d required %0d", ov_cyc[0], s + 11);
    end
  endtask

  task automatic test_long_strobe();
    int s, dmy;
    clear_log();
    host_write(1'b0, 8'hA0, 1, dmy);
    host_write(1'b1, 8'h5A, 20, s);
    host_write(1'b1, 8'h5B, 1, dmy);
    repeat (30) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() != 2) begin
      n_fail++; $display("FAIL long_count: got %0d valids required 2", ev_cyc.size());
    end
    n_checks++;
    if ((ev_cyc.size() > 1 ? {ev_addr[0], ev_data[0], ev_addr[1], ev_data[1]} : 32'hxxxxxxxx) !== 32'hA05AA05B) begin
      n_fail++; $display("FAIL long_values: got %h%h %h%h required a05a a05b", ev_addr[0], ev_data[0], ev_addr[1], ev_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    int s, dmy;
    clear_log();
    host_write(1'b0, 8'h30, 1, dmy);
    host_write(1'b1, 8'h01, 1, s);
    host_write(1'b1, 8'h02, 1, dmy);
    host_write(1'b1, 8'h03, 1, dmy);
    #1;
    ic_n = 1'b0;
    #2;
    n_checks++;
    if ({reg_wr, busy, overflow} !== 19'h0) begin
      n_fail++; $display("FAIL midreset_out: got out=%h busy=%b ovf=%b required all 0", reg_wr, busy, overflow);
    end
    repeat (2) @(posedge clk);
    #1;
    ic_n = 1'b1;
    clear_log();
    repeat (30) @(negedge clk);
    n_checks++;
    if (ev_cyc.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_quiet: got %0d valids busy=%b required 0 and 0", ev_cyc.size(), busy);
    end
    host_write(1'b1, 8'h77, 1, s);
    repeat (15) @(negedge clk);
    n_checks++;
    if ((ev_cyc.size() == 1 ? {ev_addr[0], ev_data[0]} : 16'hxxxx) !== 16'h0077) begin
      n_fail++; $display("FAIL midreset_new: got %0d valids first %h%h required one 0077", ev_cyc.size(), ev_addr[0], ev_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_overflow();
    test_long_strobe();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
